// File: rtl/cc_branch_unit_pkg.sv
// Shared definitions for the condition-code branch unit: branch condition
// encodings and the resolver state encoding.
package cc_branch_unit_pkg;

  localparam logic [2:0] COND_NEVER  = 3'b000;
  localparam logic [2:0] COND_ALWAYS = 3'b001;
  localparam logic [2:0] COND_Z      = 3'b010;
  localparam logic [2:0] COND_NZ     = 3'b011;
  localparam logic [2:0] COND_N      = 3'b100;
  localparam logic [2:0] COND_NN     = 3'b101;
  localparam logic [2:0] COND_POS    = 3'b110;
  localparam logic [2:0] COND_NPOS   = 3'b111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_CC = 2'd1,
    RESOLVE = 2'd2
  } state_t;

  // Never/always do not look at the flags, so they never wait for them.
  function automatic logic cond_unconditional(input logic [2:0] cond);
    return cond[2:1] == 2'b00;
  endfunction

endpackage

// File: rtl/cc_branch_unit_if.sv
// Bus between the comparator/control unit and the branch unit.
// master = comparator + control FSM side, slave = branch unit.
interface cc_branch_unit_if #(
  parameter int DATA_W = 16
);

  logic              CC_Z;
  logic              CC_N;
  logic              cc_load;
  logic              cc_issue;
  logic              br_req;
  logic [2:0]        br_cond;
  logic [DATA_W-1:0] br_target;
  logic              br_ack;
  logic              br_taken;
  logic              br_err;
  logic              pc_load;
  logic [DATA_W-1:0] pc_target;
  logic              flag_z;
  logic              flag_n;

  modport master (
    output CC_Z, CC_N, cc_load, cc_issue, br_req, br_cond, br_target,
    input  br_ack, br_taken, br_err, pc_load, pc_target, flag_z, flag_n
  );

  modport slave (
    input  CC_Z, CC_N, cc_load, cc_issue, br_req, br_cond, br_target,
    output br_ack, br_taken, br_err, pc_load, pc_target, flag_z, flag_n
  );

endinterface

// File: rtl/cc_cond_eval.sv
// Combinational branch condition evaluator over the registered Z/N flags.
module cc_cond_eval
  import cc_branch_unit_pkg::*;
(
  input  logic [2:0] br_cond,
  input  logic       flag_z,
  input  logic       flag_n,
  output logic       cond_true
);

  // Decode the selected condition against the current flags.
  always_comb begin
    cond_true = 1'b0;
    case (br_cond)
      COND_NEVER:  cond_true = 1'b0;
      COND_ALWAYS: cond_true = 1'b1;
      COND_Z:      cond_true = flag_z;
      COND_NZ:     cond_true = ~flag_z;
      COND_N:      cond_true = flag_n;
      COND_NN:     cond_true = ~flag_n;
      COND_POS:    cond_true = ~flag_n & ~flag_z;
      COND_NPOS:   cond_true = flag_n | flag_z;
      default:     cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/cc_branch_unit.sv
// Branch resolver: keeps the comparator flags, tracks an outstanding
// flag-setting op, and resolves branch requests once the flags are current.
// A branch stuck waiting for flags is forced not-taken after TIMEOUT cycles.
// TIMEOUT must be at least 2.
module cc_branch_unit
  import cc_branch_unit_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 8
) (
  input logic            clk,
  input logic            rst,
  cc_branch_unit_if.slave bus
);

  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tmo_q, tmo_d;
  logic [2:0]        cond_q, cond_d;
  logic [DATA_W-1:0] tgt_q, tgt_d;
  logic              flag_z_q, flag_n_q;
  logic              pending_q;
  logic              cond_true;

  // Flag register: captures the comparator flags whenever they are strobed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else if (bus.cc_load) begin
      // NOTE: non-blocking so every register here samples pre-edge values,
      // independent of the order the always blocks are evaluated in.
      flag_z_q <= bus.CC_Z;
      flag_n_q <= bus.CC_N;
    end
  end

  // Pending bit: a newly issued op wins over a load in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= 1'b0;
    end else begin
      pending_q <= bus.cc_issue | (pending_q & ~bus.cc_load);
    end
  end

  cc_cond_eval u_cond_eval (
    .br_cond   (cond_q),
    .flag_z    (flag_z_q),
    .flag_n    (flag_n_q),
    .cond_true (cond_true)
  );

  // FSM state plus captured branch context and wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
      cond_q  <= COND_NEVER;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      cond_q  <= cond_d;
      tgt_q   <= tgt_d;
    end
  end

  // Next-state logic and Moore outputs of the resolver.
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves one unassigned, which would infer a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    tmo_d        = tmo_q;
    cond_d       = cond_q;
    tgt_d        = tgt_q;
    bus.br_ack   = 1'b0;
    bus.br_taken = 1'b0;
    bus.br_err   = 1'b0;
    bus.pc_load  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.br_req) begin
          cond_d = bus.br_cond;
          tgt_d  = bus.br_target;
          tmo_d  = 1'b0;
          if (cond_unconditional(bus.br_cond) || (!pending_q && !bus.cc_issue)) begin
            state_d = RESOLVE;
          end else begin
            state_d = WAIT_CC;
            cnt_d   = '0;
          end
        end
      end

      WAIT_CC: begin
        if (bus.cc_load && !bus.cc_issue) begin
          // Flags land at this same edge, so RESOLVE sees them.
          state_d = RESOLVE;
        end else if (bus.cc_load) begin
          // A newer op superseded these flags: restart the wait.
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RESOLVE;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RESOLVE: begin
        bus.br_ack   = 1'b1;
        bus.br_taken = cond_true & ~tmo_q;
        bus.br_err   = tmo_q;
        bus.pc_load  = cond_true & ~tmo_q;
        tmo_d        = 1'b0;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.pc_target = tgt_q;
  assign bus.flag_z    = flag_z_q;
  assign bus.flag_n    = flag_n_q;

endmodule

// File: tb/tb_cc_branch_unit.sv
// Self-checking bench for cc_branch_unit: a condition sweep table plus
// hand-written pending/timeout/reset sequences. Expected acks are queued
// when a request is driven and compared when the DUT acks.
module tb_cc_branch_unit;
  import cc_branch_unit_pkg::*;

  localparam int DATA_W  = 16;
  localparam int TIMEOUT = 8;

  typedef struct {
    int               ack_cyc;
    logic             taken;
    logic             err;
    logic [DATA_W-1:0] target;
  } exp_t;

  typedef struct {
    logic       z;
    logic       n;
    logic [2:0] cond;
    logic       taken;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];
  vec_t vecs[32];

  // Taken mask per flag pattern, bit index = br_cond.
  logic [1:0] zn_tab [4]   = '{2'b00, 2'b10, 2'b01, 2'b11};
  logic [7:0] mask_tab [4] = '{8'h6A, 8'hA6, 8'h9A, 8'h96};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cc_branch_unit_if #(.DATA_W(DATA_W)) bus ();

  cc_branch_unit #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_flags(input logic z, input logic n);
    bus.CC_Z    = z;
    bus.CC_N    = n;
    bus.cc_load = 1'b1;
    step();
    bus.cc_load = 1'b0;
    check("flag_z", 32'(bus.flag_z), 32'(z));
    check("flag_n", 32'(bus.flag_n), 32'(n));
  endtask

  task automatic issue_op();
    bus.cc_issue = 1'b1;
    step();
    bus.cc_issue = 1'b0;
  endtask

  task automatic req(input logic [2:0] c, input logic [DATA_W-1:0] t, input int lat,
                     input logic tk, input logic er);
    exp_t e;
    e.ack_cyc = cyc + lat;
    e.taken   = tk;
    e.err     = er;
    e.target  = t;
    sb.push_back(e);
    bus.br_req    = 1'b1;
    bus.br_cond   = c;
    bus.br_target = t;
  endtask

  // Wait (bounded) for the ack, drop br_req on it, then move to the next cycle.
  task automatic wait_ack(input int bound);
    bit got = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (bus.br_ack) begin
        got = 1'b1;
        break;
      end
      step();
    end
    bus.br_req = 1'b0;
    if (!got) begin
      check("ack_wait", 32'd0, 32'd1);
      sb.delete();
    end
    step();
  endtask

  // Scoreboard monitor: compare each ack against the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (bus.br_ack) begin
        if (sb.size() == 0) begin
          check("unexpected_ack", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
          check("br_taken", 32'(bus.br_taken), 32'(e.taken));
          check("br_err", 32'(bus.br_err), 32'(e.err));
          check("pc_load", 32'(bus.pc_load), 32'(e.taken));
          if (e.taken) check("pc_target", 32'(bus.pc_target), 32'(e.target));
        end
      end else begin
        check("idle_outputs", {29'd0, bus.pc_load, bus.br_taken, bus.br_err}, 32'd0);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int g = 0; g < 4; g++) begin
      for (int c = 0; c < 8; c++) begin
        vecs[g*8+c] = '{zn_tab[g][1], zn_tab[g][0], 3'(c), mask_tab[g][c]};
      end
    end

    rst           = 1'b1;
    bus.CC_Z      = 1'b0;
    bus.CC_N      = 1'b0;
    bus.cc_load   = 1'b0;
    bus.cc_issue  = 1'b0;
    bus.br_req    = 1'b0;
    bus.br_cond   = 3'b000;
    bus.br_target = '0;
    #12;
    check("rst_outputs", {28'd0, bus.br_ack, bus.br_taken, bus.br_err, bus.pc_load}, 32'd0);
    check("rst_flags", {30'd0, bus.flag_z, bus.flag_n}, 32'd0);
    check("rst_pc_target", 32'(bus.pc_target), 32'd0);
    step();
    rst = 1'b0;
    step();

    // Basic taken branch, no flags pending.
    load_flags(1'b1, 1'b0);
    step();
    req(COND_Z, 16'h00A4, 1, 1'b1, 1'b0);
    wait_ack(4);

    // Condition sweep over four flag patterns.
    for (int i = 0; i < 32; i++) begin
      load_flags(vecs[i].z, vecs[i].n);
      req(vecs[i].cond, 16'h1000 + 16'(i), 1, vecs[i].taken, 1'b0);
      wait_ack(4);
    end

    // Pending wait; br_cond/br_target changes after capture are ignored.
    issue_op();
    req(COND_NZ, 16'h0BEE, 4, 1'b1, 1'b0);
    step();
    bus.br_cond   = COND_NEVER;
    bus.br_target = 16'hDEAD;
    step();
    step();
    bus.CC_Z    = 1'b0;
    bus.CC_N    = 1'b0;
    bus.cc_load = 1'b1;
    step();
    bus.cc_load = 1'b0;
    check("pend_flag_z", 32'(bus.flag_z), 32'd0);
    wait_ack(4);

    // Op issued in the same cycle as the request forces a wait.
    req(COND_N, 16'h4444, 3, 1'b1, 1'b0);
    bus.cc_issue = 1'b1;
    step();
    bus.cc_issue = 1'b0;
    step();
    bus.CC_Z    = 1'b0;
    bus.CC_N    = 1'b1;
    bus.cc_load = 1'b1;
    step();
    bus.cc_load = 1'b0;
    wait_ack(4);

    // Simultaneous load+issue keeps waiting; the later lone load decides.
    issue_op();
    req(COND_Z, 16'h5A5A, 4, 1'b1, 1'b0);
    step();
    bus.CC_Z     = 1'b0;
    bus.CC_N     = 1'b0;
    bus.cc_load  = 1'b1;
    bus.cc_issue = 1'b1;
    step();
    bus.cc_load  = 1'b0;
    bus.cc_issue = 1'b0;
    check("simul_flag_z", 32'(bus.flag_z), 32'd0);
    step();
    bus.CC_Z    = 1'b1;
    bus.cc_load = 1'b1;
    step();
    bus.cc_load = 1'b0;
    wait_ack(4);

    // Timeout: flags never arrive; Z=1 would otherwise make this taken.
    issue_op();
    req(COND_Z, 16'h7777, TIMEOUT + 1, 1'b0, 1'b1);
    wait_ack(TIMEOUT + 6);

    // Unconditional branches resolve immediately even with flags pending.
    req(COND_ALWAYS, 16'hBEEF, 1, 1'b1, 1'b0);
    wait_ack(4);
    req(COND_NEVER, 16'hCAFE, 1, 1'b0, 1'b0);
    wait_ack(4);
    load_flags(1'b1, 1'b1);

    // Reset mid-WAIT_CC: outputs and flags clear without a clock edge.
    issue_op();
    req(COND_Z, 16'h1234, 99, 1'b1, 1'b0);
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    check("midrst_outputs", {28'd0, bus.br_ack, bus.br_taken, bus.br_err, bus.pc_load}, 32'd0);
    check("midrst_flags", {30'd0, bus.flag_z, bus.flag_n}, 32'd0);
    check("midrst_pc_target", 32'(bus.pc_target), 32'd0);
    sb.delete();
    bus.br_req = 1'b0;
    step();
    rst = 1'b0;
    step();

    // After reset nothing is pending: !Z with Z=0 resolves in one cycle.
    req(COND_NZ, 16'h0F0F, 1, 1'b1, 1'b0);
    wait_ack(4);
    step();

    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
